// File: rtl/sync_fifo_pkg.sv
// Shared constants, sizing helpers and operation encoding for the parametrised synchronous FIFO.
// Used by sync_fifo_param and fifo_regmem.
package sync_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Accepted-operation encoding: {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_regmem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset.
module fifo_regmem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [WIDTH-1:0]  wrData_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic [WIDTH-1:0]  rdData_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty thresholds and error pulses.
// Define FIFO_FWFT_EN for first-word fall-through output; default is a registered 1-cycle read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write,
    input  logic                   read,
    input  logic [WIDTH-1:0]       data_in,
    output logic [WIDTH-1:0]       data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [clog2(DEPTH):0]  count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    localparam bit DEPTH_OK  = is_pow2(DEPTH) && (DEPTH >= 4) && (WIDTH >= 1);
    localparam bit THRESH_OK = (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH);

    if (!DEPTH_OK) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4, WIDTH >= 1");
    end
    if (!THRESH_OK) begin : g_bad_thresh
        $error("sync_fifo_param: need AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             full_q, empty_q, almostFull_q, almostEmpty_q;
    logic             overflow_q, underflow_q;
    logic             ptrFull, ptrEmpty, readAcc, writeAcc;
    logic [WIDTH-1:0] memRdData;
    fifo_op_e         op;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign ptrEmpty = (wrPtr_q == rdPtr_q);
    assign ptrFull  = (wrPtr_q[ADDR_W-1:0] == rdPtr_q[ADDR_W-1:0]) &&
                      (wrPtr_q[ADDR_W] != rdPtr_q[ADDR_W]);
    assign readAcc  = read && !ptrEmpty;
    assign writeAcc = write && (!ptrFull || readAcc);
    assign op       = fifo_op_e'({writeAcc, readAcc});

    always_comb begin
        wrPtr_d = writeAcc ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d = readAcc  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d = count_q;
        unique case (op)
            OP_WRITE: count_d = count_q + PTR_W'(1);
            OP_READ:  count_d = count_q - PTR_W'(1);
            default:  count_d = count_q;
        endcase
    end

    fifo_regmem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk      (clk),
        .wrEn_i   (writeAcc),
        .wrAddr_i (wrPtr_q[ADDR_W-1:0]),
        .wrData_i (data_in),
        .rdAddr_i (rdPtr_q[ADDR_W-1:0]),
        .rdData_o (memRdData)
    );

    // Flags come from the next-state count so they line up with count itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almostFull_q  <= 1'b0;
            almostEmpty_q <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            full_q        <= (count_d == PTR_W'(DEPTH));
            empty_q       <= (count_d == '0);
            almostFull_q  <= (count_d >= PTR_W'(AF_THRESH));
            almostEmpty_q <= (count_d <= PTR_W'(AE_THRESH));
            overflow_q    <= write && !writeAcc;
            underflow_q   <= read && !readAcc;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty_q ? '0 : memRdData;
`else
    logic [WIDTH-1:0] dataOut_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataOut_q <= '0;
        end else if (readAcc) begin
            dataOut_q <= memRdData;
        end
    end

    assign data_out = dataOut_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almostFull_q;
    assign almost_empty = almostEmpty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=16): vector table plus queue-model scoreboard.
// Handles both the registered-read build and the FIFO_FWFT_EN build.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;
    localparam int NVEC  = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             write = 1'b0;
    logic             read = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]       count;

    int assertCount = 0;
    int failCount = 0;

    // Reference model: the queue holds words the DUT still owes us.
    logic [WIDTH-1:0] modelQ[$];
    logic [WIDTH-1:0] expData = '0;
    logic             expOvf = 1'b0;
    logic             expUnf = 1'b0;

    typedef struct {
        logic             wr;
        logic             rd;
        logic [WIDTH-1:0] din;
        int               expCount;
        logic             expOvf;
        logic             expUnf;
    } vec_t;

    vec_t vecs [NVEC];

    sync_fifo_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write        (write),
        .read         (read),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        expData = '0;
        expOvf  = 1'b0;
        expUnf  = 1'b0;
    endtask

    // Every output compared against the queue model's view of the FIFO.
    task automatic checkOutput(input string tag);
        int n;
        n = modelQ.size();
        checkValue({tag, " count"},        32'(count),        32'(n));
        checkValue({tag, " empty"},        32'(empty),        32'(n == 0));
        checkValue({tag, " full"},         32'(full),         32'(n == DEPTH));
        checkValue({tag, " almost_full"},  32'(almost_full),  32'(n >= AF));
        checkValue({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        checkValue({tag, " overflow"},     32'(overflow),     32'(expOvf));
        checkValue({tag, " underflow"},    32'(underflow),    32'(expUnf));
        checkValue({tag, " data_out"},     32'(data_out),     32'(expData));
    endtask

    task automatic applyStimulus(input logic w, input logic r, input logic [WIDTH-1:0] d);
        bit rdAcc;
        bit wrAcc;
        write   = w;
        read    = r;
        data_in = d;
        @(posedge clk);
        rdAcc = r && (modelQ.size() > 0);
        wrAcc = w && ((modelQ.size() < DEPTH) || rdAcc);
        if (rdAcc) expData = modelQ.pop_front();
        if (wrAcc) modelQ.push_back(d);
        expOvf = w && !wrAcc;
        expUnf = r && !rdAcc;
`ifdef FIFO_FWFT_EN
        expData = (modelQ.size() > 0) ? modelQ[0] : '0;
`endif
        #1;
    endtask

    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d, input string tag);
        applyStimulus(w, r, d);
        checkOutput(tag);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 8'hxx, 0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 8'hxx, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'h07, 1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'h27, 2, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h37, 3, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h97, 4, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h17, 5, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'h77, 6, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h67, 7, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'hab, 8, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'hxx, 7, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'hxx, 6, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'hxx, 5, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 8'hxx, 4, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 8'hxx, 3, 1'b0, 1'b0};

        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        checkOutput("reset");
        reset = 1'b1;

        // Underflow after reset, then eight writes and five ordered reads.
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].din, "vec");
            checkValue("vec count",     32'(count),     32'(vecs[i].expCount));
            checkValue("vec overflow",  32'(overflow),  32'(vecs[i].expOvf));
            checkValue("vec underflow", 32'(underflow), 32'(vecs[i].expUnf));
        end

        // Fill to full, drop a 17th write, then drain.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hxx, "drain");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h10 + i), "fill");
        step(1'b1, 1'b0, 8'h55, "overflow write");
        checkValue("overflow pulse", 32'(overflow), 32'd1);
        checkValue("full after drop", 32'(full), 32'd1);
        step(1'b0, 1'b0, 8'hxx, "after overflow");
        checkValue("overflow cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'hxx, "drain full");
            checkValue("dropped word absent", 32'(data_out == 8'h55), 32'd0);
        end

        // Simultaneous read/write while full, crossing the pointer wrap.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h20 + i), "refill");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 8'(8'hd0 + i), "full rw");
            checkValue("full rw count", 32'(count), 32'd16);
        end
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'hxx, "drain wrap");
        step(1'b0, 1'b1, 8'hxx, "empty read");

        // Asynchronous reset mid-cycle with data in flight.
        step(1'b1, 1'b0, 8'h3c, "pre-reset");
        step(1'b1, 1'b0, 8'h4d, "pre-reset");
        step(1'b1, 1'b0, 8'h5e, "pre-reset");
        write = 1'b0;
        #2 reset = 1'b0;
        #1;
        modelReset();
        checkOutput("async reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("held reset");
        step(1'b0, 1'b1, 8'hxx, "read after reset");

        // Single word through, then popped.
        step(1'b1, 1'b0, 8'ha5, "write a5");
        step(1'b0, 1'b1, 8'hxx, "read a5");
        step(1'b0, 1'b0, 8'hxx, "idle");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised successor to the team's 8x8 synchronous FIFO. Generalised in width and depth, with occupancy count, programmable almost-full/almost-empty thresholds, and registered overflow/underflow error pulses. Single clock domain. Used as a generic rate-smoothing buffer between same-clock producers and consumers.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; must be a power of 2, >=4
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
write  input  1  write request; data_in is captured when accepted
read  input  1  read request
data_in  input  WIDTH  write data
data_out  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: a write was dropped
underflow  output  1  one-cycle pulse: a read was dropped

Behaviour:
- Reset, asynchronous while reset=0:
  - pointers=0, count=0, data_out=0
  - empty=1, almost_empty=1, full=0, almost_full=0
  - overflow=0, underflow=0
  - memory contents are not reset
- Pointers are ADDR_W+1 bits, where ADDR_W=$clog2(DEPTH).
  - Address = low ADDR_W bits; wrap is natural modulo.
  - full: addresses equal and MSBs differ. empty: pointers equal.
- Write acceptance: accepted when write=1 and (!full or read accepted in the same cycle).
  - Accepted: mem[wr_ptr] <= data_in, then wr_ptr increments.
- Read acceptance: accepted when read=1 and !empty.
  - Accepted: data_out <= mem[rd_ptr] (1-cycle latency; valid the cycle after the read edge), then rd_ptr increments.
  - Not accepted: data_out holds its last value.
- Simultaneous read and write:
  - Not empty: both accepted; count unchanged.
  - Full: both accepted; full stays 1.
  - Empty: write accepted, read dropped; underflow pulses.
- Count: +1 on write only, -1 on read only, unchanged on both or neither.
  - All status flags are registered and derived from the next-state count, so they are valid in the same cycle as count.
- Errors:
  - overflow=1 in the cycle after a write dropped because the FIFO was full.
  - underflow=1 in the cycle after a read dropped because the FIFO was empty.
  - Both are single-cycle pulses; state is not corrupted.
- Reset asserted mid-operation: immediate return to the reset state; in-flight data is lost.
- data_in is don't-care when write=0; X/Z on data_in must not propagate while write=0.

Optional Feature:
FIFO_FWFT_EN
- Defined (first-word fall-through):
  - data_out = mem[rd_ptr] combinationally whenever !empty; 0 when empty.
  - read pops the word already presented; word is valid with zero read latency.
  - The first word is visible 1 cycle after its write.
  - Simultaneous read and write while empty: read is dropped with underflow, as in standard mode.
- Undefined: standard registered read, exactly as described in Behaviour.

Decomposition:
- Package sync_fifo_pkg holds:
  - ADDR_W derivation helper (clog2 function)
  - default WIDTH/DEPTH constants
  - localparam checks: DEPTH is a power of 2; AE_THRESH < AF_THRESH <= DEPTH
- One sub-module, fifo_regmem: a DEPTH x WIDTH register array with one write port and one asynchronous read port.
- Pointers, count, flags and the data_out register stay in sync_fifo_param.

Test Plan:
1. Reset, then write 07,27,37,97,17,77,67,ab (WIDTH=8, DEPTH=16) -> count=8, empty=0, full=0; 5 reads return 07,27,37,97,17 in order, each one cycle after its read.
2. 16 writes followed by a 17th write of 55 -> full=1, almost_full=1 from count 14; overflow pulses one cycle; 16 reads never return 55.
3. Read while empty after reset -> underflow pulses one cycle, data_out stays 00, count stays 0.
4. With the FIFO full, write=1 and read=1 together for 4 cycles -> count stays 16, full stays 1, no overflow; read order stays FIFO-correct across the pointer wrap.
5. Write 3 words, then pull reset low between clock edges -> all outputs at reset values immediately, without waiting for an edge; a subsequent read gives underflow.
6. FIFO_FWFT_EN defined: write a5 -> data_out=a5 the cycle after the write with empty=0; read pops it, empty=1 and data_out=00 next cycle.
